uart_tx_fifo: RTL and testbench

Byte FIFO and handshake sequencer that sits directly upstream of the UART transmitter. Producers such as command handlers and debug printers push bytes at any rate. The block buffers them and presents them one at a time on the transmitter's TX_DV / TX_BYTE / DONE handshake, waiting for each frame to finish before issuing the next. The transmitter is 12 MHz, 8N1, and has no reset.

---
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter over its TX_DV / TX_BYTE / DONE handshake.
// One byte is issued per frame; the sequencer waits for DONE to fall and rise again before the next.
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [7:0]        wr_data_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   count_o,
   output logic              overflow_o,
   output logic              tx_dv_o,
   output logic [7:0]        tx_byte_o,
   input  logic              tx_done_i
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

   state_t            state_q, state_d;
   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              tx_dv_q, tx_dv_d;
   logic [7:0]        tx_byte_q;
   logic              wr_accept;
   logic              pop;

   assign full_o     = (count_q == FULL_COUNT);
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign overflow_o = overflow_q;
   assign tx_dv_o    = tx_dv_q;
   assign tx_byte_o  = tx_byte_q;

   // FULL is judged on the pre-edge count, so a same-cycle pop never rescues a write
   assign wr_accept = wr_en_i && !full_o;
   assign pop       = (state_q == S_IDLE) && !empty_o && tx_done_i;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (wr_en_i && full_o) begin
         overflow_d = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Next-state logic; DONE during ISSUE is stale, hence the mandatory busy/done round trip
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (pop) state_d = S_ISSUE;
         S_ISSUE:     state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: if (!tx_done_i) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (tx_done_i) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_dv_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_dv_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_dv_q    <= tx_dv_d;
      end
   end

   // Storage has no reset so it can map onto block RAM
   always_ff @(posedge clk_i) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_byte_q <= 8'h00;
      end else if (pop) begin
         tx_byte_q <= mem_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural 8N1 transmitter (4 clocks per bit)
// and a serial-line receiver; expected bytes flow through a scoreboard queue.
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       tx_dv;
   logic [7:0] tx_byte;
   logic       tx_done;
   logic       hold_low;

   int n_checks = 0;
   int n_fail   = 0;
   int dv_cnt   = 0;
   int rx_cnt   = 0;
   int max_count = 0;
   logic track_en;
   logic prev_dv = 1'b0;

   logic [7:0] exp_q [$];
   logic [7:0] rx_q [$];
   logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

   uart_tx_fifo #(.DEPTH(16)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .full_o     (full),
      .empty_o    (empty),
      .count_o    (count),
      .overflow_o (overflow),
      .tx_dv_o    (tx_dv),
      .tx_byte_o  (tx_byte),
      .tx_done_i  (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural transmitter: no reset, DONE registered one cycle behind its state
   localparam int M_IDLE = 0, M_START = 1, M_DATA = 2, M_STOP = 3;
   int         m_state = M_IDLE;
   int         m_clk   = 0;
   int         m_bit   = 0;
   logic [7:0] m_byte  = 8'h00;
   logic       m_line  = 1'b1;
   logic       m_done  = 1'b1;

   assign tx_done = hold_low ? 1'b0 : m_done;

   always @(posedge clk) begin
      m_done <= (m_state == M_IDLE);
      case (m_state)
         M_IDLE: begin
            m_line <= 1'b1;
            if (tx_dv) begin
               m_byte  <= tx_byte;
               m_line  <= 1'b0;
               m_clk   <= 0;
               m_state <= M_START;
            end
         end
         M_START: begin
            if (m_clk == 3) begin
               m_clk   <= 0;
               m_bit   <= 0;
               m_line  <= m_byte[0];
               m_state <= M_DATA;
            end else m_clk <= m_clk + 1;
         end
         M_DATA: begin
            if (m_clk == 3) begin
               m_clk <= 0;
               if (m_bit == 7) begin
                  m_line  <= 1'b1;
                  m_state <= M_STOP;
               end else begin
                  m_line <= m_byte[m_bit + 1];
                  m_bit  <= m_bit + 1;
               end
            end else m_clk <= m_clk + 1;
         end
         default: begin
            if (m_clk == 3) begin
               m_clk   <= 0;
               m_state <= M_IDLE;
            end else m_clk <= m_clk + 1;
         end
      endcase
   end

   // Strobe monitor: pops the scoreboard and forwards the byte to the line receiver's queue
   always @(negedge clk) begin
      logic [7:0] e;
      if (tx_dv) begin
         dv_cnt++;
         chk("dv_while_busy", tx_done, 1);
         chk("dv_two_cycles", prev_dv, 0);
         if (exp_q.size() == 0) begin
            chk("dv_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("tx_byte_order", tx_byte, e);
            rx_q.push_back(e);
         end
         $display("[%0t] issue tx_byte=0x%02h count=%0d", $time, tx_byte, count);
      end
      prev_dv = tx_dv;
      if (!track_en) max_count = 0;
      else if (int'(count) > max_count) max_count = int'(count);
   end

   // Serial receiver sampling mid-bit
   initial begin
      logic [7:0] b;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (m_line == 1'b0) begin
            repeat (2) @(negedge clk);
            chk("rx_start_bit", m_line, 0);
            for (int j = 0; j < 8; j++) begin
               repeat (4) @(negedge clk);
               b[j] = m_line;
            end
            repeat (4) @(negedge clk);
            chk("rx_stop_bit", m_line, 1);
            rx_cnt++;
            if (rx_q.size() == 0) begin
               chk("rx_unexpected", 1, 0);
            end else begin
               e = rx_q.pop_front();
               chk("rx_byte", b, e);
            end
            $display("[%0t] line byte 0x%02h", $time, b);
         end
      end
   end

   task automatic wait_idle(input int budget);
      int stable = 0;
      for (int k = 0; k < budget && stable < 4; k++) begin
         tick();
         if (exp_q.size() == 0 && rx_q.size() == 0 && tx_done && count == 0) stable++;
         else stable = 0;
      end
      if (stable < 4) chk("idle_timeout", 0, 1);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int base;
      int rxb;
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; hold_low = 1'b0; track_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_tx_dv", tx_dv, 0);
      chk("rst_tx_byte", tx_byte, 8'h00);
      rst = 1'b0;
      repeat (2) tick();

      // Single byte latency
      wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
      tick();
      wr_en = 1'b0;
      chk("sb_c1_count", count, 1);
      chk("sb_c1_empty", empty, 0);
      chk("sb_c1_dv", tx_dv, 0);
      tick();
      chk("sb_c2_dv", tx_dv, 1);
      chk("sb_c2_byte", tx_byte, 8'hA5);
      chk("sb_c2_count", count, 0);
      chk("sb_c2_empty", empty, 1);
      tick();
      chk("sb_c3_dv", tx_dv, 0);
      wait_idle(200);

      // "Hello" burst
      base = dv_cnt; rxb = rx_cnt;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = hello[i]; exp_q.push_back(hello[i]);
         tick();
      end
      wr_en = 1'b0;
      wait_idle(600);
      chk("hello_dv_pulses", dv_cnt - base, 5);
      chk("hello_rx_bytes", rx_cnt - rxb, 5);

      // Fill and overflow with DONE held low
      hold_low = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         if (i < 16) exp_q.push_back(8'(i));
         tick();
         if (i == 15) begin
            chk("fill_full", full, 1);
            chk("fill_count16", count, 16);
            chk("fill_no_ovf_yet", overflow, 0);
         end
      end
      wr_en = 1'b0;
      chk("ovf_set", overflow, 1);
      chk("ovf_count16", count, 16);
      tick();
      hold_low = 1'b0;
      base = dv_cnt;
      wait_idle(1200);
      chk("fill_dv_pulses", dv_cnt - base, 16);
      chk("ovf_sticky", overflow, 1);
      apply_reset();
      chk("ovf_cleared", overflow, 0);

      // Wrap-around streaming, one write per frame
      track_en = 1'b1;
      base = dv_cnt;
      for (int i = 0; i < 40; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h80 + i); exp_q.push_back(8'(8'h80 + i));
         tick();
         wr_en = 1'b0;
         repeat (49) tick();
      end
      wait_idle(200);
      chk("wrap_count_gt2", max_count > 2, 0);
      track_en = 1'b0;
      chk("wrap_overflow", overflow, 0);
      chk("wrap_dv_pulses", dv_cnt - base, 40);

      // Simultaneous push and pop with COUNT == 1
      hold_low = 1'b1;
      wr_en = 1'b1; wr_data = 8'h11; exp_q.push_back(8'h11);
      tick();
      wr_en = 1'b0;
      repeat (2) tick();
      chk("pp_pre_count", count, 1);
      hold_low = 1'b0;
      wr_en = 1'b1; wr_data = 8'h22; exp_q.push_back(8'h22);
      tick();
      wr_en = 1'b0;
      chk("pp_dv", tx_dv, 1);
      chk("pp_byte", tx_byte, 8'h11);
      chk("pp_count", count, 1);
      wait_idle(300);

      // Reset during a frame
      base = dv_cnt;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h31 + i); exp_q.push_back(8'(8'h31 + i));
         tick();
      end
      wr_en = 1'b0;
      for (int k = 0; k < 50 && dv_cnt == base; k++) tick();
      chk("mf_started", dv_cnt - base, 1);
      repeat (10) tick();
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("mf_async_count", count, 0);
      chk("mf_async_empty", empty, 1);
      repeat (2) tick();
      rst = 1'b0;
      chk("mf_count", count, 0);
      chk("mf_empty", empty, 1);
      chk("mf_overflow", overflow, 0);
      chk("mf_dv", tx_dv, 0);
      base = dv_cnt;
      for (int k = 0; k < 100 && !tx_done; k++) tick();
      chk("mf_done_rose", tx_done, 1);
      chk("mf_no_strobes", dv_cnt - base, 0);
      wr_en = 1'b1; wr_data = 8'h7E; exp_q.push_back(8'h7E);
      tick();
      wr_en = 1'b0;
      chk("mf_c1_count", count, 1);
      chk("mf_c1_dv", tx_dv, 0);
      tick();
      chk("mf_c2_dv", tx_dv, 1);
      chk("mf_c2_byte", tx_byte, 8'h7E);
      wait_idle(200);
      chk("final_exp_empty", exp_q.size(), 0);
      chk("final_rx_empty", rx_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
